// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the FSM state encoding and the decode constants for RTI and IN/OUT.
package intc_pkg;

    localparam int N_IRQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_e;

    // Decode constants the CPU uses to generate rti_retire and ien_we
    localparam logic [3:0] OP_RTI = 4'b1011;
    localparam logic [1:0] RA_RTI = 2'b11;
    localparam logic [3:0] OP_IO  = 4'b0111;
    localparam logic [1:0] RA_OUT = 2'b10;
    localparam logic [1:0] RA_IN  = 2'b11;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser chain plus a history flop that yields a one-cycle
// rise pulse. History resets to 0, so a line held high across reset gives an edge.
module irq_sync_edge
    import intc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/intr_controller.sv
// Interrupt requester for the pipelined CPU: latches IRQ edges, arbitrates by
// fixed priority (lowest index wins) and runs the INTR / Inject_Int / RTI handshake.
module intr_controller
    import intc_pkg::*;
#(
    parameter  int N_IRQ       = N_IRQ_DEF,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             int_ack,
    input  logic             rti_retire,
    input  logic             ien_we,
    input  logic [N_IRQ-1:0] ien_wdata,
    output logic             INTR,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] irq_pending,
    output logic             irq_overrun
);

    function automatic logic [ID_W-1:0] prio_enc(input logic [N_IRQ-1:0] v);
        prio_enc = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (v[i]) prio_enc = ID_W'(i);
    endfunction

    logic [N_IRQ-1:0] rise;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (irq_in[g]),
            .rise     (rise[g])
        );
    end

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] ien_q, ien_d;
    logic [N_IRQ-1:0] clr;
    logic [ID_W-1:0]  id_q, id_d;
    logic             intr_q, intr_d;
    logic             svc_q, svc_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        intr_d  = intr_q;
        svc_d   = svc_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (|(pend_q & ien_q)) begin
                    id_d    = prio_enc(pend_q & ien_q);
                    intr_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // id and INTR stay frozen here regardless of ien/pending changes
                if (int_ack) begin
                    clr     = N_IRQ'(1) << id_q;
                    intr_d  = 1'b0;
                    svc_d   = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (rti_retire) begin
                    svc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                intr_d  = 1'b0;
                svc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        // A new edge on the line being acked wins over the clear and is not an overrun
        pend_d = (pend_q & ~clr) | rise;
        ovr_d  = |(rise & pend_q & ~clr);
        ien_d  = ien_we ? ien_wdata : ien_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ien_q   <= '1;
            id_q    <= '0;
            intr_q  <= 1'b0;
            svc_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ien_q   <= ien_d;
            id_q    <= id_d;
            intr_q  <= intr_d;
            svc_q   <= svc_d;
            ovr_q   <= ovr_d;
        end
    end

    assign INTR        = intr_q;
    assign irq_id      = id_q;
    assign in_service  = svc_q;
    assign irq_pending = pend_q;
    assign irq_overrun = ovr_q;

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller: directed scenarios plus random
// traffic, every cycle compared against a behavioural model.
module tb_intr_controller;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq_in = '0;
    logic         int_ack = 1'b0;
    logic         rti_retire = 1'b0;
    logic         ien_we = 1'b0;
    logic [N-1:0] ien_wdata = '0;
    logic         INTR;
    logic [1:0]   irq_id;
    logic         in_service;
    logic [N-1:0] irq_pending;
    logic         irq_overrun;

    intr_controller #(.N_IRQ(N), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .int_ack     (int_ack),
        .rti_retire  (rti_retire),
        .ien_we      (ien_we),
        .ien_wdata   (ien_wdata),
        .INTR        (INTR),
        .irq_id      (irq_id),
        .in_service  (in_service),
        .irq_pending (irq_pending),
        .irq_overrun (irq_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: requests travel through a pin-sample delay line, then
    // the handshake is tracked as "requesting" / "in service" / neither.
    logic [N-1:0] m_pend = '0, m_ien = '1;
    logic         m_intr = 1'b0, m_svc = 1'b0, m_ovr = 1'b0;
    int           m_id = 0;
    logic [N-1:0] sh0 = '0, sh1 = '0, sh2 = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] rise, clr, elig;
        @(posedge clk);
        if (rst) begin
            m_pend = '0; m_ien = '1; m_intr = 0; m_svc = 0; m_ovr = 0; m_id = 0;
            sh0 = '0; sh1 = '0; sh2 = '0;
        end else begin
            rise  = sh1 & ~sh2;
            clr   = (m_intr && int_ack) ? N'(1 << m_id) : '0;
            m_ovr = |(rise & m_pend & ~clr);
            elig  = m_pend & m_ien;
            m_pend = (m_pend & ~clr) | rise;
            if (m_intr) begin
                if (int_ack) begin m_intr = 0; m_svc = 1; end
            end else if (m_svc) begin
                if (rti_retire) m_svc = 0;
            end else if (elig != 0) begin
                for (int i = N - 1; i >= 0; i--) if (elig[i]) m_id = i;
                m_intr = 1;
            end
            if (ien_we) m_ien = ien_wdata;
            sh2 = sh1; sh1 = sh0; sh0 = irq_in;
        end
        #1;
        chk("intr",    32'(INTR),        32'(m_intr));
        chk("svc",     32'(in_service),  32'(m_svc));
        chk("pending", 32'(irq_pending), 32'(m_pend));
        chk("overrun", 32'(irq_overrun), 32'(m_ovr));
        if (m_intr) chk("id", 32'(irq_id), 32'(m_id));
        rst = 0; int_ack = 0; rti_retire = 0; ien_we = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int ovr_cnt;
        // Reset
        rst = 1; step();
        chk("rst_intr", 32'(INTR), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_pend", 32'(irq_pending), 0);

        // Single line 2, latency
        irq_in = 4'b0100; step(); irq_in = '0; steps(2);
        chk("lat_early", 32'(INTR), 0);
        step();
        chk("lat_intr", 32'(INTR), 1);
        chk("lat_id", 32'(irq_id), 2);
        int_ack = 1; step();
        chk("ack_intr", 32'(INTR), 0);
        chk("ack_pend2", 32'(irq_pending[2]), 0);
        chk("ack_svc", 32'(in_service), 1);
        steps(3);
        chk("svc_hold", 32'(in_service), 1);
        rti_retire = 1; step();
        chk("rti_svc", 32'(in_service), 0);

        // Priority 3 vs 1
        irq_in = 4'b1010; step(); irq_in = '0; steps(3);
        chk("prio_id", 32'(irq_id), 1);
        int_ack = 1; step(); steps(2);
        rti_retire = 1; step();
        chk("prio_gap", 32'(INTR), 0);
        step();
        chk("prio_re", 32'(INTR), 1);
        chk("prio_id3", 32'(irq_id), 3);
        int_ack = 1; step(); rti_retire = 1; step();

        // Masking line 0
        ien_we = 1; ien_wdata = 4'b1110; step();
        irq_in = 4'b0001; step(); irq_in = '0; steps(5);
        chk("mask_pend", 32'(irq_pending[0]), 1);
        chk("mask_intr", 32'(INTR), 0);
        ien_we = 1; ien_wdata = 4'b1111; step(); step();
        chk("unmask_intr", 32'(INTR), 1);
        chk("unmask_id", 32'(irq_id), 0);

        // Hold in REQ while masked, ack delayed
        ien_we = 1; ien_wdata = 4'b1110; step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_intr", 32'(INTR), 1);
            chk("hold_id", 32'(irq_id), 0);
        end
        int_ack = 1; step(); rti_retire = 1; step();
        ien_we = 1; ien_wdata = 4'b1111; step();

        // Coalesce / overrun on line 1
        irq_in = 4'b0010; step(); irq_in = '0; steps(3);
        chk("coal_req", 32'(INTR), 1);
        irq_in = 4'b0010; step(); irq_in = '0;
        ovr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (irq_overrun) ovr_cnt++;
        end
        chk("coal_ovr_cnt", 32'(ovr_cnt), 1);
        int_ack = 1; step();
        chk("coal_pend", 32'(irq_pending[1]), 0);
        rti_retire = 1; step(); steps(5);
        chk("coal_once", 32'(INTR), 0);

        // Edge on line 1 coincident with its ack
        irq_in = 4'b0010; step(); irq_in = '0; steps(3);
        irq_in = 4'b0010; step(); irq_in = '0; step();
        int_ack = 1; step();
        chk("coin_pend", 32'(irq_pending[1]), 1);
        chk("coin_ovr", 32'(irq_overrun), 0);
        rti_retire = 1; step(); step();
        chk("coin_re", 32'(INTR), 1);
        chk("coin_id", 32'(irq_id), 1);
        int_ack = 1; step(); rti_retire = 1; step();

        // Reset mid-service
        irq_in = 4'b1000; step(); irq_in = '0; steps(3);
        int_ack = 1; step();
        chk("mid_svc", 32'(in_service), 1);
        rst = 1; step();
        chk("mid_rst_svc", 32'(in_service), 0);
        chk("mid_rst_intr", 32'(INTR), 0);
        rti_retire = 1; step();
        chk("mid_rti_ign", 32'(in_service), 0);
        chk("mid_rti_intr", 32'(INTR), 0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
            int_ack    = ($urandom_range(0, 3) == 0);
            rti_retire = ($urandom_range(0, 5) == 0);
            ien_we     = ($urandom_range(0, 15) == 0);
            ien_wdata  = N'($urandom);
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
